// File: rtl/cache_mem_arbiter.sv
// Two-port Wishbone classic arbiter: I-cache (port 0) and D-cache (port 1) share one memory port.
// Define ARBITER_ROUND_ROBIN_EN to alternate on conflicts; otherwise port 1 has fixed priority.
module cache_mem_arbiter #(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int SEL_SIZE   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 req_cyc,
  input  logic [1:0]                 req_stb,
  input  logic [1:0]                 req_we,
  input  logic [1:0][ADDR_SIZE-1:0]  req_addr,
  input  logic [1:0][SEL_SIZE-1:0]   req_sel,
  input  logic [1:0][BLOCK_SIZE-1:0] req_dat_o,
  output logic [1:0]                 req_ack,
  output logic [1:0][BLOCK_SIZE-1:0] req_dat_i,
  output logic                       mem_cyc,
  output logic                       mem_stb,
  output logic                       mem_we,
  output logic [ADDR_SIZE-1:0]       mem_addr,
  output logic [SEL_SIZE-1:0]        mem_sel,
  output logic [BLOCK_SIZE-1:0]      mem_dat_o,
  input  logic [BLOCK_SIZE-1:0]      mem_dat_i,
  input  logic                       mem_ack
);

  localparam int NUM_PORTS = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_SIZE-1:0]  addr;
    logic [SEL_SIZE-1:0]   sel;
    logic [BLOCK_SIZE-1:0] dat;
  } wb_req_t;

  wb_req_t [NUM_PORTS-1:0] req;
  wb_req_t                 mem_req;

  logic [1:0] state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       owner, owner_vld, conflict_win;
  logic [1:0] req_vld;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign req[i]       = '{cyc: req_cyc[i], stb: req_stb[i], we: req_we[i],
                            addr: req_addr[i], sel: req_sel[i], dat: req_dat_o[i]};
    assign req_vld[i]   = req_cyc[i] & req_stb[i];
    assign req_ack[i]   = !reset && owner_vld && (owner == 1'(i)) && mem_ack;
    assign req_dat_i[i] = reset ? '0 : mem_dat_i;
  end

  assign owner     = (state == OWN1);
  assign owner_vld = !reset && ((state == OWN0) || (state == OWN1));
  assign mem_req   = owner_vld ? req[owner] : '0;

  assign mem_cyc   = mem_req.cyc;
  assign mem_stb   = mem_req.stb;
  assign mem_we    = mem_req.we;
  assign mem_addr  = mem_req.addr;
  assign mem_sel   = mem_req.sel;
  assign mem_dat_o = mem_req.dat;

`ifdef ARBITER_ROUND_ROBIN_EN
  assign conflict_win = ~last_grant;
`else
  assign conflict_win = 1'b1;
`endif

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (req_vld == 2'b11)  state_nxt = conflict_win ? OWN1 : OWN0;
        else if (req_vld[0])   state_nxt = OWN0;
        else if (req_vld[1])   state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        // Ack wins over a same-cycle abort so a completed transfer is always recorded.
        if (mem_ack) begin
          state_nxt      = IDLE;
          last_grant_nxt = owner;
        end else if (!req_cyc[owner]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
`define CHK(tag, obs, exp) chk(tag, 128'(obs), 128'(exp))

module tb_cache_mem_arbiter;
  localparam int AW = 32, BW = 128, SW = 16;

`ifdef ARBITER_ROUND_ROBIN_EN
  localparam int FIRST = 0;
  localparam logic [2:0] T4_OWNER = 3'b110;
`else
  localparam int FIRST = 1;
  localparam logic [2:0] T4_OWNER = 3'b111;
`endif
  localparam int SECOND = 1 - FIRST;

  localparam logic [BW-1:0] D_IDLE = 128'h55AA_1234_5678_9ABC_CAFE_F00D_0BAD_BEEF;
  localparam logic [BW-1:0] D_RD   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [BW-1:0] D_WR   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          req_cyc, req_stb, req_we, req_ack;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][SW-1:0]  req_sel;
  logic [1:0][BW-1:0]  req_dat_o, req_dat_i;
  logic                mem_cyc, mem_stb, mem_we, mem_ack;
  logic [AW-1:0]       mem_addr;
  logic [SW-1:0]       mem_sel;
  logic [BW-1:0]       mem_dat_o, mem_dat_i;

  int vectors = 0;
  int miscompares = 0;

  cache_mem_arbiter #(.ADDR_SIZE(AW), .BLOCK_SIZE(BW), .SEL_SIZE(SW)) dut (
    .clock(clock), .reset(reset),
    .req_cyc(req_cyc), .req_stb(req_stb), .req_we(req_we),
    .req_addr(req_addr), .req_sel(req_sel), .req_dat_o(req_dat_o),
    .req_ack(req_ack), .req_dat_i(req_dat_i),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      vectors++;
      if (req_dat_i[0] !== req_dat_i[1]) begin
        miscompares++;
        $error("FAIL mon_bcast: %0h vs %0h", req_dat_i[0], req_dat_i[1]);
      end
      if (req_ack === 2'b11) begin
        miscompares++;
        $error("FAIL mon_dual_ack");
      end
      if ((req_ack !== 2'b00) && (mem_cyc !== 1'b1)) begin
        miscompares++;
        $error("FAIL mon_ack_no_cyc: ack=%b cyc=%b", req_ack, mem_cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_cyc = '0; req_stb = '0; req_we = '0;
    req_addr = '0; req_sel = '0; req_dat_o = '0;
    mem_ack = 1'b0; mem_dat_i = D_IDLE;

    repeat (2) @(posedge clock);
    #1;
    `CHK("rst_cyc", mem_cyc, 1'b0);
    `CHK("rst_ack", req_ack, 2'b00);
    `CHK("rst_dat0", req_dat_i[0], '0);
    `CHK("rst_addr", mem_addr, '0);
    reset = 1'b0;
    #1;
    `CHK("dat_bcast1", req_dat_i[1], D_IDLE);

    req_cyc[0] = 1'b1; req_stb[0] = 1'b1; req_addr[0] = 32'h100; req_sel[0] = 16'hFFFF;
    #1;
    `CHK("t1_idle_cyc", mem_cyc, 1'b0);
    tick();
    `CHK("t1_cyc", mem_cyc, 1'b1);
    `CHK("t1_addr", mem_addr, 32'h100);
    `CHK("t1_we", mem_we, 1'b0);
    `CHK("t1_noack", req_ack, 2'b00);
    tick(); tick();
    mem_ack = 1'b1; mem_dat_i = D_RD;
    #1;
    `CHK("t1_ack", req_ack, 2'b01);
    `CHK("t1_dat", req_dat_i[0], D_RD);
    tick();
    mem_ack = 1'b0; req_cyc[0] = 1'b0; req_stb[0] = 1'b0;
    #1;
    `CHK("t1_gap", mem_cyc, 1'b0);
    mem_ack = 1'b1;
    #1;
    `CHK("idle_ack_ignored", req_ack, 2'b00);
    mem_ack = 1'b0;

    tick();
    req_cyc[1] = 1'b1; req_stb[1] = 1'b1; req_we[1] = 1'b1;
    req_addr[1] = 32'h2000; req_sel[1] = 16'hFFFF; req_dat_o[1] = D_WR;
    tick();
    `CHK("t2_we", mem_we, 1'b1);
    `CHK("t2_dat", mem_dat_o, D_WR);
    `CHK("t2_sel", mem_sel, 16'hFFFF);
    `CHK("t2_addr", mem_addr, 32'h2000);
    mem_ack = 1'b1;
    #1;
    `CHK("t2_ack", req_ack, 2'b10);
    tick();
    mem_ack = 1'b0; req_cyc[1] = 1'b0; req_stb[1] = 1'b0; req_we[1] = 1'b0;
    #1;
    `CHK("t2_gap", mem_cyc, 1'b0);

    reset = 1'b1;
    #1;
    reset = 1'b0;
    req_addr[0] = 32'h300; req_addr[1] = 32'h400;
    req_cyc = 2'b11; req_stb = 2'b11;
    tick();
    `CHK("t3_first_addr", mem_addr, (FIRST == 0) ? 32'h300 : 32'h400);
    mem_ack = 1'b1;
    #1;
    `CHK("t3_first_ack", req_ack, (FIRST == 0) ? 2'b01 : 2'b10);
    tick();
    mem_ack = 1'b0; req_cyc[FIRST] = 1'b0; req_stb[FIRST] = 1'b0;
    #1;
    `CHK("t3_gap", mem_cyc, 1'b0);
    tick();
    `CHK("t3_second_addr", mem_addr, (SECOND == 0) ? 32'h300 : 32'h400);
    mem_ack = 1'b1;
    #1;
    `CHK("t3_second_ack", req_ack, (SECOND == 0) ? 2'b01 : 2'b10);
    tick();
    mem_ack = 1'b0; req_cyc = 2'b00; req_stb = 2'b00;

    req_addr[0] = 32'h600; req_addr[1] = 32'h500;
    req_cyc = 2'b11; req_stb = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      `CHK("t4_addr", mem_addr, T4_OWNER[k] ? 32'h500 : 32'h600);
      mem_ack = 1'b1;
      #1;
      `CHK("t4_ack", req_ack, T4_OWNER[k] ? 2'b10 : 2'b01);
      tick();
      mem_ack = 1'b0;
      if (!T4_OWNER[k]) begin
        req_cyc[0] = 1'b0; req_stb[0] = 1'b0;
      end
    end
    req_cyc = 2'b00; req_stb = 2'b00;
    tick();

    req_addr[0] = 32'h700; req_cyc[0] = 1'b1; req_stb[0] = 1'b1;
    tick();
    `CHK("t5_cyc", mem_cyc, 1'b1);
    req_cyc[0] = 1'b0; req_stb[0] = 1'b0;
    #1;
    `CHK("t5_drop_cyc", mem_cyc, 1'b0);
    tick();
    mem_ack = 1'b1;
    #1;
    `CHK("t5_late_ack", req_ack, 2'b00);
    mem_ack = 1'b0;

    req_addr[0] = 32'h800; req_cyc[0] = 1'b1; req_stb[0] = 1'b1;
    tick();
    `CHK("t6_cyc", mem_cyc, 1'b1);
    mem_ack = 1'b1; mem_dat_i = D_RD;
    reset = 1'b1;
    #1;
    `CHK("t6_rst_cyc", mem_cyc, 1'b0);
    `CHK("t6_rst_ack", req_ack, 2'b00);
    `CHK("t6_rst_dat", req_dat_i[0], '0);
    mem_ack = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    `CHK("t6_idle", mem_cyc, 1'b0);
    tick();
    `CHK("t6_regrant", mem_cyc, 1'b1);
    `CHK("t6_regrant_addr", mem_addr, 32'h800);
    req_cyc = 2'b00; req_stb = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
